// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory view.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [DATA_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  ls_req;
  logic                  ls_wen;
  logic [DATA_WIDTH-1:0] ls_addr;
  logic [DATA_WIDTH-1:0] ls_wdata;
  logic [3:0]            ls_wmask;
  logic                  ls_gnt;
  logic                  ls_rvalid;
  logic [DATA_WIDTH-1:0] ls_rdata;

  logic                  mem_req;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wmask;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_wen, ls_addr, ls_wdata, ls_wmask,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_wen, ls_addr, ls_wdata, ls_wmask,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the fetch and load/store ports, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin on conflicts; otherwise load/store always beats fetch.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic                  owner_reg, owner_next;
  logic                  mem_wen_reg;
  logic [DATA_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_wdata_reg;
  logic [3:0]            mem_wmask_reg;

  logic grant;
  logic pick_ls;
  logic complete;
  logic prefer_ls;

`ifdef MEM_ARB_RR_EN
  // Remembers who won the last grant; starts at fetch so load/store takes the first conflict.
  logic last_ls_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ls_reg <= 1'b0;
    end else if (grant) begin
      last_ls_reg <= pick_ls;
    end
  end

  assign prefer_ls = ~last_ls_reg;
`else
  assign prefer_ls = 1'b1;
`endif

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    grant      = 1'b0;
    pick_ls    = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.if_req || bus.ls_req) begin
          grant      = 1'b1;
          pick_ls    = bus.ls_req && (!bus.if_req || prefer_ls);
          owner_next = pick_ls;
          state_next = REQ;
        end
      end
      REQ: begin
        // A response arriving with the grant finishes the transaction without visiting RESP.
        if (bus.mem_gnt) begin
          if (bus.mem_rvalid) begin
            complete   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RESP;
          end
        end
      end
      RESP: begin
        if (bus.mem_rvalid) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Grants and responses are suppressed while reset is held, not just after the next edge.
    if (rst) begin
      grant    = 1'b0;
      complete = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      owner_reg     <= 1'b0;
      mem_wen_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wmask_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      if (grant) begin
        mem_wen_reg   <= pick_ls & bus.ls_wen;
        mem_addr_reg  <= pick_ls ? bus.ls_addr  : bus.if_addr;
        mem_wdata_reg <= pick_ls ? bus.ls_wdata : '0;
        mem_wmask_reg <= pick_ls ? bus.ls_wmask : 4'h0;
      end else if (complete) begin
        // Clearing on completion keeps the memory bus quiet while idle.
        mem_wen_reg   <= 1'b0;
        mem_addr_reg  <= '0;
        mem_wdata_reg <= '0;
        mem_wmask_reg <= '0;
      end
    end
  end

  assign bus.if_gnt    = grant & ~pick_ls;
  assign bus.ls_gnt    = grant & pick_ls;
  assign bus.if_rvalid = complete & ~owner_reg;
  assign bus.ls_rvalid = complete & owner_reg;
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.ls_rdata  = bus.ls_rvalid ? bus.mem_rdata : '0;

  assign bus.mem_req   = (state_reg == REQ);
  assign bus.mem_wen   = mem_wen_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_wmask = mem_wmask_reg;

endmodule
